// File: rtl/hh_neuron_scheduler.sv
// Round-robin scheduler sharing one Hodgkin-Huxley core across virtual neurons.
// Feeds spikes back as synaptic current and queues spike events for readout.
module hh_neuron_scheduler #(
    parameter int              WIDTH       = 16,
    parameter int              NUM_NEURONS = 4,
    parameter int              IDX_W       = 2,
    parameter int              STEPS_W     = 16,
    parameter logic [WIDTH-1:0] SYN_GAIN   = WIDTH'(16'h0A00),
    parameter int              TIMEOUT     = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [WIDTH-1:0]   cfg_stim,
    input  logic               start,
    input  logic               abort,
    input  logic [STEPS_W-1:0] step_count,
    output logic               busy,
    output logic               done,
    output logic [STEPS_W-1:0] steps_done,
    output logic               timeout_err,
    output logic               core_ready_in,
    output logic [WIDTH-1:0]   core_i_stim,
    output logic [WIDTH-1:0]   core_i_syn,
    output logic [IDX_W-1:0]   neuron_sel,
    input  logic               core_valid_out,
    input  logic               core_spike,
    output logic               spike_valid,
    output logic [IDX_W-1:0]   spike_idx,
    output logic [STEPS_W-1:0] spike_step,
    input  logic               spike_ready,
    output logic [7:0]         drop_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, RECORD, NEXT, FIN
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       k_q, k_d;
    logic [STEPS_W-1:0]     steps_q, steps_d;
    logic [STEPS_W-1:0]     count_q, count_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   spk_q, spk_d;
    logic                   terr_q, terr_d;
    logic [NUM_NEURONS-1:0] prev_q, prev_d;
    logic [NUM_NEURONS-1:0] cur_q, cur_d;
    logic [NUM_NEURONS-1:0] others;
    logic                   push;

    logic [WIDTH-1:0]       stim_q [NUM_NEURONS];

    logic [IDX_W-1:0]       fidx_q  [DEPTH];
    logic [STEPS_W-1:0]     fstep_q [DEPTH];
    logic [1:0]             wr_q, rd_q;
    logic [2:0]             cnt_q;
    logic [7:0]             drop_q;
    logic                   pop, full, accept;

    // FSM and run-control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            steps_q <= '0;
            count_q <= '0;
            timer_q <= '0;
            spk_q   <= 1'b0;
            terr_q  <= 1'b0;
            prev_q  <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            steps_q <= steps_d;
            count_q <= count_d;
            timer_q <= timer_d;
            spk_q   <= spk_d;
            terr_q  <= terr_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
        end
    end

    // Next-state logic; abort preempts every active state
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        steps_d = steps_q;
        count_d = count_q;
        timer_d = timer_q;
        spk_d   = spk_q;
        terr_d  = terr_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        push    = 1'b0;
        if (abort && state_q != IDLE && state_q != FIN) begin
            state_d = FIN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        count_d = step_count;
                        steps_d = '0;
                        terr_d  = 1'b0;
                        k_d     = '0;
                        state_d = (step_count == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    timer_d = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (core_valid_out) begin
                        spk_d   = core_spike;
                        state_d = RECORD;
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        terr_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                RECORD: begin
                    if (spk_q) begin
                        cur_d[k_q] = 1'b1;
                        push       = 1'b1;
                    end
                    state_d = NEXT;
                end
                NEXT: begin
                    if (k_q != IDX_W'(NUM_NEURONS - 1)) begin
                        k_d     = k_q + IDX_W'(1);
                        state_d = ISSUE;
                    end else begin
                        prev_d  = cur_q;
                        cur_d   = '0;
                        steps_d = steps_q + STEPS_W'(1);
                        k_d     = '0;
                        if ((steps_q + STEPS_W'(1)) == count_q) begin
                            state_d = FIN;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
                FIN: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stimulus registers, writable only between runs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) stim_q[i] <= '0;
        end else if (state_q == IDLE && cfg_we &&
                     ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_NEURONS))) begin
            stim_q[cfg_idx] <= cfg_stim;
        end
    end

    // Core-facing outputs; synaptic drive excludes the neuron's own spike
    always_comb begin
        others          = prev_q;
        others[k_q]     = 1'b0;
        core_ready_in   = (state_q == ISSUE);
        core_i_stim     = '0;
        core_i_syn      = '0;
        if (state_q == ISSUE) begin
            core_i_stim = stim_q[k_q];
            core_i_syn  = (others != '0) ? SYN_GAIN : '0;
        end
    end

    assign pop    = spike_ready && (cnt_q != 3'd0);
    assign full   = (cnt_q == 3'(DEPTH));
    assign accept = push && (!full || pop);

    // Spike event FIFO with saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fidx_q[i]  <= '0;
                fstep_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (accept) begin
                fidx_q[wr_q]  <= k_q;
                fstep_q[wr_q] <= steps_q;
                wr_q          <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + 3'(accept) - 3'(pop);
            if (push && !accept && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign steps_done  = steps_q;
    assign timeout_err = terr_q;
    assign neuron_sel  = k_q;
    assign spike_valid = (cnt_q != 3'd0);
    assign spike_idx   = spike_valid ? fidx_q[rd_q] : '0;
    assign spike_step  = spike_valid ? fstep_q[rd_q] : '0;
    assign drop_count  = drop_q;

endmodule
